// File: rtl/two24_acc_ctrl.sv
// Sequencer for a DSP48E2 slice in TWO24 SIMD mode acting as a dual 24-bit
// unsigned accumulator: accepts NACC packed beats per frame, steers CE/RST/
// OPMODE of the slice, then presents both lane sums with sticky overflow.
`timescale 1ns/1ps
module two24_acc_ctrl #(
  parameter int unsigned NACC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [47:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [47:0] m_tdata,
  output logic [1:0]  m_tovf,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [47:0] dsp_ab_o,
  output logic        dsp_ce_ab_o,
  output logic        dsp_ce_p_o,
  output logic        dsp_rst_p_o,
  output logic [8:0]  dsp_opmode_o,
  input  logic [47:0] dsp_p_i,
  input  logic [1:0]  dsp_carry_i
);

  localparam int unsigned DATA_W   = 48;
  localparam int unsigned OPMODE_W = 9;
  localparam int unsigned CNT_W    = $clog2(NACC + 1);

  localparam logic [1:0] X_OPMODE_AB = 2'b11;
  localparam logic [1:0] Y_OPMODE_0  = 2'b00;
  localparam logic [2:0] Z_OPMODE_0  = 3'b000;
  localparam logic [2:0] Z_OPMODE_P  = 3'b010;

  // P = AB (first beat) or P = P + AB (later beats)
  localparam logic [OPMODE_W-1:0] OPMODE_LOAD  = {2'b00, Z_OPMODE_0, Y_OPMODE_0, X_OPMODE_AB};
  localparam logic [OPMODE_W-1:0] OPMODE_ACCUM = {2'b00, Z_OPMODE_P, Y_OPMODE_0, X_OPMODE_AB};

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NACC - 1);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic                flush_q;
  logic                s_tready_q;
  logic                m_tvalid_q;
  logic [DATA_W-1:0]   m_tdata_q;

  logic                ce_p_q;
  logic                ce_first_q;
  logic [OPMODE_W-1:0] opmode_q;
  logic                fold_q;
  logic                fold_first_q;
  logic [1:0]          ovf_q;
  logic [1:0]          ovf_d;
  logic                rst_p_q;

  logic                beat_acc_c;
  logic                first_beat_c;

  assign beat_acc_c   = s_tvalid & s_tready_q;
  assign first_beat_c = (count_q == '0);

  // Frame sequencing: accumulate, wait out the slice pipeline, hold the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_ACC;
      count_q    <= '0;
      flush_q    <= 1'b0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          s_tready_q <= 1'b1;
          if (beat_acc_c) begin
            if (count_q == LAST_CNT) begin
              count_q    <= '0;
              s_tready_q <= 1'b0;
              flush_q    <= 1'b0;
              state_q    <= ST_FLUSH;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            flush_q    <= 1'b0;
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= dsp_p_i;
            state_q    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_tready) begin
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b1;
            state_q    <= ST_ACC;
          end
        end
        default: begin
          state_q    <= ST_ACC;
          s_tready_q <= 1'b0;
          m_tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Slice control stage: CEP and OPMODE one cycle after each accepted beat,
  // carry fold one cycle after that when P and CARRYOUT carry the beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ce_p_q       <= 1'b0;
      ce_first_q   <= 1'b0;
      opmode_q     <= OPMODE_LOAD;
      fold_q       <= 1'b0;
      fold_first_q <= 1'b0;
      ovf_q        <= 2'b00;
    end else begin
      ce_p_q       <= beat_acc_c;
      ce_first_q   <= beat_acc_c & first_beat_c;
      if (beat_acc_c) begin
        opmode_q <= first_beat_c ? OPMODE_LOAD : OPMODE_ACCUM;
      end
      fold_q       <= ce_p_q;
      fold_first_q <= ce_first_q;
      if (fold_q) begin
        ovf_q <= ovf_d;
      end
    end
  end

  // First update of a frame restarts the sticky flags instead of OR-ing in.
  always_comb begin
    ovf_d = ovf_q | dsp_carry_i;
    if (fold_first_q) begin
      ovf_d = dsp_carry_i;
    end
  end

  // Slice RSTP/RSTA/RSTB follow the block reset one cycle late.
  always_ff @(posedge clk_i) begin
    rst_p_q <= rst_i;
  end

  assign s_tready     = s_tready_q;
  assign m_tvalid     = m_tvalid_q;
  assign m_tdata      = m_tdata_q;
  assign m_tovf       = ovf_q;
  assign dsp_ab_o     = s_tdata;
  assign dsp_ce_ab_o  = beat_acc_c;
  assign dsp_ce_p_o   = ce_p_q;
  assign dsp_rst_p_o  = rst_p_q;
  assign dsp_opmode_o = opmode_q;

endmodule
